// File: rtl/height_pkg.sv
// rtl/height_pkg.sv - shared state type, default widths and ms-to-tick helper
package height_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_THRESHOLD = 48;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TIMING  = 2'd1,
      LATCHED = 2'd2
   } state_t;

   function automatic int ms_to_ticks(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/height_hist_buf.sv
// rtl/height_hist_buf.sv - newest-first capture history with saturating count
module height_hist_buf #(
   parameter int DATA_W     = 8,
   parameter int HIST_DEPTH = 10,
   localparam int CNT_W     = $clog2(HIST_DEPTH + 1)
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         save,
   input  logic                         clear,
   input  logic [DATA_W-1:0]            din,
   output logic [HIST_DEPTH*DATA_W-1:0] hist_flat,
   output logic [CNT_W-1:0]             hist_count
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(HIST_DEPTH);

   logic [DATA_W-1:0] entry_q [HIST_DEPTH];

   // A clear that coincides with a save keeps only the value being saved
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < HIST_DEPTH; i++) entry_q[i] <= '0;
         hist_count <= '0;
      end else if (clear) begin
         for (int i = 1; i < HIST_DEPTH; i++) entry_q[i] <= '0;
         entry_q[0] <= save ? din : '0;
         hist_count <= save ? CNT_W'(1) : '0;
      end else if (save) begin
         for (int i = HIST_DEPTH - 1; i > 0; i--) entry_q[i] <= entry_q[i-1];
         entry_q[0] <= din;
         if (hist_count != FULL) hist_count <= hist_count + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_flat
      assign hist_flat[g*DATA_W +: DATA_W] = entry_q[g];
   end

endmodule

// File: rtl/height_capture_ctrl.sv
// rtl/height_capture_ctrl.sv - presence/stability FSM latching minimum height into history
// Optional exit debounce: define HEIGHT_CAPTURE_EXIT_DEBOUNCE_EN.
module height_capture_ctrl
   import height_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLK_FREQ_HZ  = 12_000_000,
   parameter int HOLD_MS      = 3000,
   parameter int FLASH_MS     = 250,
   parameter int THRESHOLD    = DEF_THRESHOLD,
   parameter int STABLE_TOL   = 2,
   parameter int HIST_DEPTH   = 10,
   parameter int EXIT_SAMPLES = 4
)(
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               sample_valid,
   input  logic [DATA_W-1:0]                  sample_in,
   input  logic                               clear_hist,
   output logic [DATA_W-1:0]                  display_value,
   output logic                               display_latched,
   output logic                               save_pulse,
   output logic                               led_save,
   output logic [HIST_DEPTH*DATA_W-1:0]       hist_flat,
   output logic [$clog2(HIST_DEPTH+1)-1:0]    hist_count
);

   localparam int HOLD_TICKS  = ms_to_ticks(CLK_FREQ_HZ, HOLD_MS);
   localparam int FLASH_TICKS = ms_to_ticks(CLK_FREQ_HZ, FLASH_MS);
   localparam int HOLD_W      = $clog2(HOLD_TICKS + 2);
   localparam int FLASH_W     = $clog2(FLASH_TICKS + 2);

   localparam logic [HOLD_W-1:0]  HOLD_C   = HOLD_W'(HOLD_TICKS);
   localparam logic [FLASH_W-1:0] FLASH_C  = FLASH_W'(FLASH_TICKS);
   localparam logic [DATA_W-1:0]  THRESH_C = DATA_W'(THRESHOLD);
   localparam logic [DATA_W:0]    TOL_C    = (DATA_W+1)'(STABLE_TOL);

   if (HIST_DEPTH < 1 || EXIT_SAMPLES < 1) begin : g_param_check
      $error("height_capture_ctrl: HIST_DEPTH and EXIT_SAMPLES must be >= 1");
   end

   state_t              state_q, state_n;
   logic [HOLD_W-1:0]   hold_q, hold_n;
   logic [FLASH_W-1:0]  flash_q, flash_n;
   logic [DATA_W-1:0]   min_q, min_n, max_q, max_n;
   logic [DATA_W-1:0]   latched_q, latched_n, disp_q, disp_n;
   logic                save_q, save_n;
   logic                present, exit_fire;
   logic [DATA_W-1:0]   min_f, max_f;
   logic [DATA_W:0]     spread;

   assign present = sample_in < THRESH_C;
   assign min_f   = (sample_in < min_q) ? sample_in : min_q;
   assign max_f   = (sample_in > max_q) ? sample_in : max_q;
   assign spread  = {1'b0, max_f} - {1'b0, min_f};

`ifdef HEIGHT_CAPTURE_EXIT_DEBOUNCE_EN
   localparam int EXIT_W = $clog2(EXIT_SAMPLES + 1);
   localparam logic [EXIT_W-1:0] EXIT_LAST = EXIT_W'(EXIT_SAMPLES - 1);

   logic [EXIT_W-1:0] exit_q;

   assign exit_fire = sample_valid && !present && (exit_q == EXIT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                                  exit_q <= '0;
      else if (state_q == IDLE || exit_fire || (sample_valid && present)) exit_q <= '0;
      else if (sample_valid)                                         exit_q <= exit_q + EXIT_W'(1);
   end
`else
   assign exit_fire = sample_valid && !present;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         flash_q   <= '0;
         min_q     <= '0;
         max_q     <= '0;
         latched_q <= '0;
         disp_q    <= '0;
         save_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         hold_q    <= hold_n;
         flash_q   <= flash_n;
         min_q     <= min_n;
         max_q     <= max_n;
         latched_q <= latched_n;
         disp_q    <= disp_n;
         save_q    <= save_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      hold_n    = hold_q;
      min_n     = min_q;
      max_n     = max_q;
      latched_n = latched_q;
      save_n    = 1'b0;
      flash_n   = (flash_q != '0) ? flash_q - FLASH_W'(1) : flash_q;

      case (state_q)
         IDLE: begin
            if (sample_valid && present) begin
               state_n = TIMING;
               hold_n  = HOLD_W'(1);
               min_n   = sample_in;
               max_n   = sample_in;
            end
         end
         TIMING: begin
            if (exit_fire) begin
               state_n = IDLE;
               hold_n  = '0;
            end else if (sample_valid && present && spread > TOL_C) begin
               hold_n = HOLD_W'(1);
               min_n  = sample_in;
               max_n  = sample_in;
            end else if (hold_q >= HOLD_C) begin
               state_n   = LATCHED;
               hold_n    = '0;
               latched_n = min_q;
               save_n    = 1'b1;
               flash_n   = FLASH_C;
            end else begin
               // Above-threshold samples still pending exit must not widen the window
               hold_n = hold_q + HOLD_W'(1);
               if (sample_valid && present) begin
                  min_n = min_f;
                  max_n = max_f;
               end
            end
         end
         LATCHED: begin
            if (exit_fire) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (state_n == LATCHED)  disp_n = latched_n;
      else if (sample_valid)   disp_n = sample_in;
      else                     disp_n = disp_q;
   end

   assign display_value   = disp_q;
   assign display_latched = (state_q == LATCHED);
   assign save_pulse      = save_q;
   assign led_save        = (flash_q != '0);

   height_hist_buf #(
      .DATA_W     (DATA_W),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk        (clk),
      .reset_n    (reset_n),
      .save       (save_q),
      .clear      (clear_hist),
      .din        (latched_q),
      .hist_flat  (hist_flat),
      .hist_count (hist_count)
   );

endmodule

// File: tb/tb_height_capture_ctrl.sv
// tb/tb_height_capture_ctrl.sv - directed self-checking bench for height_capture_ctrl
module tb_height_capture_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_valid;
   logic [7:0]  sample_in;
   logic        clear_hist;
   logic [7:0]  display_value;
   logic        display_latched;
   logic        save_pulse;
   logic        led_save;
   logic [79:0] hist_flat;
   logic [3:0]  hist_count;

   int errors = 0;
   int checks = 0;
   int n, leds, pulses;

`ifdef HEIGHT_CAPTURE_EXIT_DEBOUNCE_EN
   localparam int EXITN = 4;
   int lat6 [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
`else
   localparam int EXITN = 1;
   int lat6 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
   int seq6 [8] = '{60, 60, 60, 30, 60, 60, 60, 60};

   height_capture_ctrl #(
      .DATA_W       (8),
      .CLK_FREQ_HZ  (1000),
      .HOLD_MS      (10),
      .FLASH_MS     (5),
      .THRESHOLD    (48),
      .STABLE_TOL   (2),
      .HIST_DEPTH   (10),
      .EXIT_SAMPLES (4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sample_valid    (sample_valid),
      .sample_in       (sample_in),
      .clear_hist      (clear_hist),
      .display_value   (display_value),
      .display_latched (display_latched),
      .save_pulse      (save_pulse),
      .led_save        (led_save),
      .hist_flat       (hist_flat),
      .hist_count      (hist_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] entry(input int i);
      return hist_flat[i*8 +: 8];
   endfunction

   task automatic drive(input logic v, input logic [7:0] s);
      sample_valid = v;
      sample_in    = s;
      @(posedge clk);
      #1;
   endtask

   task automatic exit_latched();
      repeat (EXITN) drive(1'b1, 8'd60);
   endtask

   task automatic capture(input logic [7:0] v);
      repeat (11) drive(1'b1, v);
      chk("cap_pulse", {31'd0, save_pulse}, 1);
      exit_latched();
   endtask

   initial begin
      reset_n      = 1'b0;
      sample_valid = 1'b0;
      sample_in    = 8'd0;
      clear_hist   = 1'b0;
      #12;
      chk("rst_display", {24'd0, display_value}, 0);
      chk("rst_latched", {31'd0, display_latched}, 0);
      chk("rst_save", {31'd0, save_pulse}, 0);
      chk("rst_led", {31'd0, led_save}, 0);
      chk("rst_count", {28'd0, hist_count}, 0);
      chk("rst_hist_flat", {31'd0, |hist_flat}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Basic capture: latency, display, flash length, history
      repeat (3) drive(1'b1, 8'd60);
      drive(1'b1, 8'd30);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 8'd30);
         if (save_pulse) begin
            n = k;
            break;
         end
      end
      chk("t1_latency", n, 10);
      chk("t1_display", {24'd0, display_value}, 30);
      chk("t1_latched", {31'd0, display_latched}, 1);
      leds = 0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         if (led_save) leds++;
         if (save_pulse) pulses++;
         drive(1'b1, 8'd30);
      end
      chk("t1_led_len", leds, 5);
      chk("t1_pulse_once", pulses, 1);
      chk("t1_count", {28'd0, hist_count}, 1);
      chk("t1_entry0", {24'd0, entry(0)}, 30);
      exit_latched();
      chk("t1_exit", {31'd0, display_latched}, 0);
      chk("t1_exit_display", {24'd0, display_value}, 60);

      // Spread violation restarts the window
      drive(1'b1, 8'd30);
      drive(1'b1, 8'd31);
      drive(1'b1, 8'd29);
      drive(1'b1, 8'd34);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 8'd34);
         if (save_pulse) begin
            n = k;
            break;
         end
      end
      chk("t2_latency", n, 10);
      chk("t2_display", {24'd0, display_value}, 34);
      exit_latched();
      chk("t2_count", {28'd0, hist_count}, 2);
      chk("t2_entry0", {24'd0, entry(0)}, 34);
      chk("t2_entry1", {24'd0, entry(1)}, 30);

      // Short presence aborts without saving; invalid samples are ignored
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 8'd30);
         if (save_pulse) pulses++;
      end
      drive(1'b1, 8'd50);
      if (save_pulse) pulses++;
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, 8'd60);
         if (save_pulse) pulses++;
      end
      for (int k = 0; k < 15; k++) begin
         drive(1'b0, 8'd10);
         if (save_pulse) pulses++;
      end
      chk("t3_no_save", pulses, 0);
      chk("t3_idle", {31'd0, display_latched}, 0);
      chk("t3_display_hold", {24'd0, display_value}, 60);
      chk("t3_count", {28'd0, hist_count}, 2);
      chk("t3_entry0", {24'd0, entry(0)}, 34);

      // History overflow drops the oldest entries
      for (int v = 1; v <= 12; v++) capture(8'(v));
      chk("t4_count", {28'd0, hist_count}, 10);
      chk("t4_entry0", {24'd0, entry(0)}, 12);
      chk("t4_entry1", {24'd0, entry(1)}, 11);
      chk("t4_entry9", {24'd0, entry(9)}, 3);

      // Clear coinciding with a save keeps only the new value
      repeat (11) drive(1'b1, 8'd40);
      chk("t5_pulse", {31'd0, save_pulse}, 1);
      clear_hist = 1'b1;
      drive(1'b1, 8'd40);
      clear_hist = 1'b0;
      chk("t5_entry0", {24'd0, entry(0)}, 40);
      chk("t5_upper_zero", {31'd0, |hist_flat[79:8]}, 0);
      chk("t5_count", {28'd0, hist_count}, 1);
      exit_latched();
      clear_hist = 1'b1;
      drive(1'b1, 8'd60);
      clear_hist = 1'b0;
      chk("t5_clear_count", {28'd0, hist_count}, 0);
      chk("t5_clear_flat", {31'd0, |hist_flat}, 0);

      // Exit behaviour from LATCHED
      repeat (11) drive(1'b1, 8'd20);
      chk("t6_latched", {31'd0, display_latched}, 1);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 8'(seq6[k]));
         chk($sformatf("t6_exit_%0d", k), {31'd0, display_latched}, 32'(lat6[k]));
      end

      // Reset during the flash aborts everything
      repeat (11) drive(1'b1, 8'd25);
      chk("t7_led_on", {31'd0, led_save}, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t7_led", {31'd0, led_save}, 0);
      chk("t7_save", {31'd0, save_pulse}, 0);
      chk("t7_latched", {31'd0, display_latched}, 0);
      chk("t7_count", {28'd0, hist_count}, 0);
      chk("t7_display", {24'd0, display_value}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1'b1, 8'd60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
